// File: rtl/bike_pkg.sv
// Shared bike-computer definitions: ride state encoding, default speed
// parameters and trip statistic widths.
package bike_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RIDE  = 2'd1,
    S_PAUSE = 2'd2,
    S_CLEAR = 2'd3
  } trip_state_e;

  localparam int WIDTH_DEF       = 12;
  localparam int SPEED_LIMIT_DEF = 999;
  localparam int TRIP_W          = 16;
  localparam int REJ_W           = 8;

endpackage

// File: rtl/btn_hold_timer.sv
// Counts whole seconds of trip-button hold and emits a one-cycle hold_done.
// Disarms after firing so one press produces one clear.
module btn_hold_timer #(
  parameter int HOLD_SEC = 2
) (
  input  logic clk,
  input  logic r,
  input  logic sec_tick,
  input  logic btn,
  output logic hold_done
);

  logic [2:0] cnt;
  logic       armed;
  logic       tick_q;

  assign tick_q    = btn && armed && sec_tick;
  assign hold_done = tick_q && (cnt == 3'(HOLD_SEC - 1));

  always_ff @(posedge clk) begin
    if (r || !btn) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else if (hold_done) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (tick_q) begin
      cnt   <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/trip_ctrl.sv
// Ride sequencing controller: IDLE/RIDE/PAUSE/CLEAR FSM, speed-sample
// filtering, riding-time and reject counters. Auto-pause is built only when
// AUTO_PAUSE_EN is defined.
module trip_ctrl
  import bike_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SPEED_LIMIT = SPEED_LIMIT_DEF,
  parameter int PAUSE_SEC   = 4,
  parameter int HOLD_SEC    = 2
) (
  input  logic              clk,
  input  logic              r,
  input  logic              sec_tick,
  input  logic              wheel_pulse,
  input  logic              speed_valid,
  input  logic [WIDTH-1:0]  speed,
  input  logic              btn,
  output logic [WIDTH-1:0]  spd_out,
  output logic              max_en,
  output logic              max_clr,
  output logic [TRIP_W-1:0] trip_sec,
  output logic [REJ_W-1:0]  rej_cnt,
  output logic [1:0]        state
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(SPEED_LIMIT);

  if (PAUSE_SEC < 1 || PAUSE_SEC > 15) begin : g_bad_pause
    $error("trip_ctrl: PAUSE_SEC out of range 1..15");
  end
  if (HOLD_SEC < 1 || HOLD_SEC > 7) begin : g_bad_hold
    $error("trip_ctrl: HOLD_SEC out of range 1..7");
  end

  trip_state_e cur, nxt;
  logic        hold_done;
  logic        pause_hit;
  logic        riding;

  assign riding = (cur == S_RIDE);

  btn_hold_timer #(.HOLD_SEC(HOLD_SEC)) u_hold (
    .clk       (clk),
    .r         (r),
    .sec_tick  (sec_tick),
    .btn       (btn),
    .hold_done (hold_done)
  );

`ifdef AUTO_PAUSE_EN
  logic [3:0] idle_cnt;

  // A wheel pulse in the same cycle as the deciding tick keeps us riding.
  assign pause_hit = riding && sec_tick && !wheel_pulse &&
                     (idle_cnt == 4'(PAUSE_SEC - 1));

  always_ff @(posedge clk) begin
    if (r || hold_done || !riding || wheel_pulse || pause_hit)
      idle_cnt <= '0;
    else if (sec_tick)
      idle_cnt <= idle_cnt + 4'd1;
  end
`else
  assign pause_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (r) cur <= S_IDLE;
    else   cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (hold_done) begin
      nxt = S_CLEAR;
    end else begin
      case (cur)
        S_IDLE:  if (wheel_pulse) nxt = S_RIDE;
        S_RIDE:  if (pause_hit)   nxt = S_PAUSE;
        S_PAUSE: if (wheel_pulse) nxt = S_RIDE;
        S_CLEAR: nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      spd_out  <= '0;
      max_en   <= 1'b0;
      max_clr  <= 1'b0;
      trip_sec <= '0;
      rej_cnt  <= '0;
    end else begin
      max_en  <= 1'b0;
      max_clr <= 1'b0;
      if (hold_done) begin
        // Clear wins over any sample or tick arriving in the same cycle.
        max_clr  <= 1'b1;
        spd_out  <= '0;
        trip_sec <= '0;
        rej_cnt  <= '0;
      end else if (riding) begin
        if (speed_valid) begin
          if (speed <= LIMIT) begin
            spd_out <= speed;
            max_en  <= 1'b1;
          end else if (rej_cnt != '1) begin
            rej_cnt <= rej_cnt + 1'b1;
          end
        end
        if (sec_tick && trip_sec != '1)
          trip_sec <= trip_sec + 1'b1;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_trip_ctrl.sv
// Directed bench for trip_ctrl: vector table for the basic ride/filter path,
// hand sequences for saturation, auto-pause, hold-to-clear and reset.
module tb_trip_ctrl;

  logic        clk = 1'b0;
  logic        r = 1'b0;
  logic        sec_tick = 1'b0;
  logic        wheel_pulse = 1'b0;
  logic        speed_valid = 1'b0;
  logic [11:0] speed = '0;
  logic        btn = 1'b0;
  logic [11:0] spd_out;
  logic        max_en;
  logic        max_clr;
  logic [15:0] trip_sec;
  logic [7:0]  rej_cnt;
  logic [1:0]  state;

  int ncmp = 0;
  int nfail = 0;

  trip_ctrl dut (
    .clk(clk), .r(r), .sec_tick(sec_tick), .wheel_pulse(wheel_pulse),
    .speed_valid(speed_valid), .speed(speed), .btn(btn),
    .spd_out(spd_out), .max_en(max_en), .max_clr(max_clr),
    .trip_sec(trip_sec), .rej_cnt(rej_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, tk, wp, sv;
    logic [11:0] spd;
    logic        b;
    logic [1:0]  st;
    logic [11:0] so;
    logic        en, clr;
    logic [15:0] ts;
    logic [7:0]  rc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic drv(input logic rr, input logic tk, input logic wp,
                     input logic sv, input logic [11:0] sp, input logic b);
    r = rr; sec_tick = tk; wheel_pulse = wp; speed_valid = sv; speed = sp; btn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st, input logic [11:0] so,
                         input logic en, input logic clr, input logic [15:0] ts,
                         input logic [7:0] rc);
    chk({nm, ".state"},    32'(state),    32'(st));
    chk({nm, ".spd_out"},  32'(spd_out),  32'(so));
    chk({nm, ".max_en"},   32'(max_en),   32'(en));
    chk({nm, ".max_clr"},  32'(max_clr),  32'(clr));
    chk({nm, ".trip_sec"}, 32'(trip_sec), 32'(ts));
    chk({nm, ".rej_cnt"},  32'(rej_cnt),  32'(rc));
  endtask

  initial begin
    int et;
    //             r  tk wp sv spd   b   st so   en clr ts rc
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,12'd0,   1'b0, 2'd0,12'd0,  1'b0,1'b0,16'd0,8'd0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,12'd0,   1'b0, 2'd0,12'd0,  1'b0,1'b0,16'd0,8'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,12'd250, 1'b0, 2'd0,12'd0,  1'b0,1'b0,16'd0,8'd0};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,12'd0,   1'b0, 2'd1,12'd0,  1'b0,1'b0,16'd0,8'd0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,12'd250, 1'b0, 2'd1,12'd250,1'b1,1'b0,16'd0,8'd0};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,12'd0,   1'b0, 2'd1,12'd250,1'b0,1'b0,16'd0,8'd0};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,12'd1000,1'b0, 2'd1,12'd250,1'b0,1'b0,16'd0,8'd1};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,12'd999, 1'b0, 2'd1,12'd999,1'b1,1'b0,16'd0,8'd1};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,12'd1000,1'b0, 2'd1,12'd999,1'b0,1'b0,16'd0,8'd2};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,12'd0,   1'b0, 2'd1,12'd999,1'b0,1'b0,16'd1,8'd2};
    tbl[10] = '{1'b0,1'b1,1'b1,1'b0,12'd0,   1'b0, 2'd1,12'd999,1'b0,1'b0,16'd2,8'd2};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,12'd0,   1'b0, 2'd1,12'd0,  1'b1,1'b0,16'd2,8'd2};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].r, tbl[i].tk, tbl[i].wp, tbl[i].sv, tbl[i].spd, tbl[i].b);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].so, tbl[i].en, tbl[i].clr,
              tbl[i].ts, tbl[i].rc);
    end

    // Reject counter saturation: 2 already counted, 253 more reach 255.
    for (int i = 0; i < 253; i++) drv(0, 0, 0, 1, 12'd4095, 0);
    chk("rej_at_255", 32'(rej_cnt), 32'd255);
    for (int i = 0; i < 47; i++) drv(0, 0, 0, 1, 12'd1000, 0);
    chk_all("rej_sat", 2'd1, 12'd0, 1'b0, 1'b0, 16'd2, 8'd255);

    et = 2;
`ifdef AUTO_PAUSE_EN
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 0, 0, 0); et++;
      chk($sformatf("pre_pause%0d.state", i), 32'(state), 32'd1);
    end
    drv(0, 1, 0, 0, 0, 0); et++;
    chk_all("pause_enter", 2'd2, 12'd0, 1'b0, 1'b0, 16'(et), 8'd255);
    drv(0, 1, 0, 1, 12'd100, 0);
    chk_all("pause_hold", 2'd2, 12'd0, 1'b0, 1'b0, 16'(et), 8'd255);
    drv(0, 0, 1, 0, 0, 0);
    chk("pause_exit.state", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) begin drv(0, 1, 0, 0, 0, 0); et++; end
    drv(0, 1, 1, 0, 0, 0); et++;
    chk_all("wheel_wins", 2'd1, 12'd0, 1'b0, 1'b0, 16'(et), 8'd255);
    drv(0, 1, 0, 0, 0, 0); et++;
    chk("after_wheel_wins.state", 32'(state), 32'd1);
`else
    for (int i = 0; i < 20; i++) begin
      drv(0, 1, 0, 0, 0, 0); et++;
      chk($sformatf("no_pause%0d.state", i), 32'(state), 32'd1);
    end
    chk("no_pause.trip_sec", 32'(trip_sec), 32'd22);
`endif
    chk("trip_track", 32'(trip_sec), 32'(et));

    // Hold-to-clear: second tick of the hold fires the clear.
    drv(0, 1, 0, 0, 0, 1); et++;
    chk_all("hold1", 2'd1, 12'd0, 1'b0, 1'b0, 16'(et), 8'd255);
    drv(0, 1, 0, 1, 12'd50, 1);
    chk_all("clear", 2'd3, 12'd0, 1'b0, 1'b1, 16'd0, 8'd0);
    drv(0, 0, 0, 0, 0, 1);
    chk_all("post_clear", 2'd0, 12'd0, 1'b0, 1'b0, 16'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 0, 0, 0, 1);
      chk($sformatf("no_reclear%0d.max_clr", i), 32'(max_clr), 32'd0);
      chk($sformatf("no_reclear%0d.state", i), 32'(state), 32'd0);
    end
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 1);
    chk("release_resets_cnt", 32'(max_clr), 32'd0);
    drv(0, 1, 0, 0, 0, 1);
    chk("reclear.max_clr", 32'(max_clr), 32'd1);
    chk("reclear.state", 32'(state), 32'd3);
    drv(0, 0, 0, 0, 0, 0);
    chk("reclear_end.max_clr", 32'(max_clr), 32'd0);

    // Reset mid-ride with trip_sec=37 and one second of hold counted.
    drv(0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 12'd500, 0);
    drv(0, 0, 0, 1, 12'd2000, 0);
    for (int i = 0; i < 36; i++) drv(0, 1, 1, 0, 0, 0);
    drv(0, 1, 1, 0, 0, 1);
    chk_all("pre_reset", 2'd1, 12'd500, 1'b0, 1'b0, 16'd37, 8'd1);
    drv(1, 1, 0, 0, 0, 1);
    chk_all("reset_mid", 2'd0, 12'd0, 1'b0, 1'b0, 16'd0, 8'd0);
    drv(0, 1, 0, 0, 0, 1);
    chk("reset_cleared_hold", 32'(max_clr), 32'd0);
    drv(0, 1, 0, 0, 0, 1);
    chk("reset_rearmed", 32'(max_clr), 32'd1);
    drv(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/trip_ctrl.md
# trip_ctrl

Trip sequencing controller for the bike computer. Owns the ride state machine (idle / riding / auto-paused / clear) and generates the enable and clear controls for the 12-bit running-maximum speed tracker. It filters implausible speed samples and keeps a saturating riding-time counter. It sits between the wheel/speed front end and the max-speed tracker, and is the only block allowed to clear trip statistics.

## Interface
- WIDTH, 12: speed sample width; must match the max-speed tracker.
- SPEED_LIMIT, 999: largest plausible speed code; larger samples are rejected.
- PAUSE_SEC, 4: whole seconds without a wheel pulse before auto-pause (range 1..15).
- HOLD_SEC, 2: whole seconds the button must be held to clear the trip (range 1..7).
- clk  in  1  single system clock.
- r  in  1  synchronous, active-high reset.
- sec_tick  in  1  one-cycle strobe, once per second.
- wheel_pulse  in  1  one-cycle strobe per wheel revolution, already debounced.
- speed_valid  in  1  one-cycle strobe; speed is valid in that cycle.
- speed  in  WIDTH  current speed sample.
- btn  in  1  trip-reset button level, already debounced.
- spd_out  out  WIDTH  registered copy of the accepted sample; drives the tracker speed input.
- max_en  out  1  one-cycle tracker enable, aligned with spd_out.
- max_clr  out  1  one-cycle tracker clear. The top level ORs it with r into the tracker reset.
- trip_sec  out  16  riding seconds, saturates at 16'hFFFF.
- rej_cnt  out  8  count of rejected samples, saturates at 8'hFF.
- state  out  2  0 IDLE, 1 RIDE, 2 PAUSE, 3 CLEAR.

## Operation
- Reset values: state=IDLE; spd_out=0; max_en=0; max_clr=0; trip_sec=0; rej_cnt=0; idle and hold counters=0; clear armed.
- IDLE -> RIDE on wheel_pulse.
- RIDE:
  - speed_valid with speed <= SPEED_LIMIT loads spd_out and pulses max_en.
  - speed_valid with speed > SPEED_LIMIT leaves spd_out unchanged, keeps max_en=0, and increments rej_cnt.
  - trip_sec increments on each sec_tick, including the tick that causes the pause transition.
- Idle counter (RIDE only):
  - wheel_pulse clears it to 0.
  - Otherwise sec_tick increments it.
  - A sec_tick that would make it equal to PAUSE_SEC moves the FSM to PAUSE instead.
  - If wheel_pulse and sec_tick arrive in the same cycle, wheel_pulse wins: counter=0, no pause.
- PAUSE: no max_en, no trip_sec increment, samples are ignored (not counted as rejected). wheel_pulse -> RIDE with the idle counter at 0.
- IDLE: samples are ignored.
- Hold counter, any state:
  - While btn=1 and clear is armed, each sec_tick increments the hold counter.
  - btn=0 clears the hold counter and re-arms clear.
  - Reaching HOLD_SEC moves the FSM to CLEAR and disarms clear, so one press gives one clear.
- CLEAR lasts exactly one cycle:
  - max_clr=1; trip_sec, rej_cnt and spd_out are zeroed; max_en=0.
  - Next state is IDLE.
- CLEAR entry has priority over every other transition and update in the same cycle.
- r asserted in any state, mid-hold or mid-pause, returns to the reset values on the next edge. max_clr is not pulsed, because r resets the tracker directly.

## Timing
- All outputs are registered.
- Accepted sample: speed_valid at edge N gives spd_out/max_en at edge N+1, so the tracker updates at edge N+2.
- max_clr rises at the edge after the qualifying sec_tick and lasts one cycle. state reads 3 for that cycle.
- Inputs are assumed synchronous to clk. Strobes wider than one cycle are counted once per cycle.

## Configuration
- AUTO_PAUSE_EN defined: idle counter and PAUSE state are built exactly as described above.
- AUTO_PAUSE_EN undefined: no idle counter is built and PAUSE is unreachable. RIDE persists until CLEAR or r. state never reads 2.

## Structure
- Shared package bike_pkg holds:
  - the 2-bit state encoding constants;
  - the default WIDTH and SPEED_LIMIT values;
  - the trip_sec and rej_cnt widths.
- One sub-module: btn_hold_timer. It covers the hold counter, the arm flag and sec_tick qualification, and emits a one-cycle hold_done.

## Test plan
- Reset, then wheel_pulse -> state=1. speed_valid with speed=250 -> next cycle spd_out=250, max_en=1 for one cycle.
- In RIDE, speed=1000 -> max_en stays 0, spd_out is unchanged, rej_cnt=1. Repeat 300 times -> rej_cnt=255.
- In RIDE, 4 sec_ticks with no wheel_pulse -> state=2, trip_sec=4. wheel_pulse -> state=1. Same-cycle wheel_pulse + 4th sec_tick -> stays 1.
- btn held across 2 sec_ticks -> max_clr one cycle, then state=0, trip_sec=0. Keep holding for 5 more ticks -> no second clear. Release, then hold 2 ticks -> clear again.
- Assert r mid-RIDE with trip_sec=37 and the hold counter at 1 -> all outputs are at reset values next cycle; max_clr stays 0.
- Build without AUTO_PAUSE_EN: 20 sec_ticks with no wheel_pulse -> state stays 1, trip_sec=20.
